// File: rtl/analyzer_capture_core.sv
// rtl/analyzer_capture_core.sv - logic-analyzer capture engine: divided sampling, pre/post trigger ring buffer, logical readback
// Ring buffer always holds DEPTH samples around the trigger; reads are indexed from the oldest sample.
module analyzer_capture_core #(
  parameter int CH_NUM     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     digital_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  trig,
  input  logic                  force_trig,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DEPTH_LOG2-1:0] pre_len,
  output logic                  busy,
  output logic                  armed,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_ptr,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [CH_NUM-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  ptr_t                 pre_q, pre_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 fill_q, fill_d;
  ptr_t                 post_q, post_d;
  ptr_t                 trig_ptr_q, trig_ptr_d;
  logic                 force_q, force_d;

  logic                 capturing;
  logic                 tick;
  logic                 start_ok;
  logic                 trig_hit;
  ptr_t                 rd_phys;

  logic [CH_NUM-1:0]    mem [DEPTH];
  logic [CH_NUM-1:0]    rd_data_q;
  logic                 rd_valid_q;

  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign tick      = capturing && (div_cnt_q == div_q);
  assign start_ok  = start && !stop && ((state_q == S_IDLE) || (state_q == S_DONE));
  // A force pulse landing on the tick cycle itself triggers that tick rather than being lost.
  assign trig_hit  = (state_q == S_WAIT) && tick && (trig || force_q || force_trig);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    pre_d      = pre_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    trig_ptr_d = trig_ptr_q;
    force_d    = force_q;

    if (stop) begin
      state_d   = S_IDLE;
      force_d   = 1'b0;
      div_cnt_d = '0;
    end else if (start_ok) begin
      div_d     = clk_div;
      pre_d     = pre_len;
      wr_ptr_d  = '0;
      fill_d    = '0;
      div_cnt_d = '0;
      force_d   = 1'b0;
      state_d   = (pre_len == '0) ? S_WAIT : S_PRE;
    end else if (capturing) begin
      if (tick) begin
        div_cnt_d = '0;
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      case (state_q)
        S_PRE: begin
          if (tick) begin
            fill_d = fill_q + ptr_t'(1);
            if (fill_d == pre_q) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (tick)            force_d = 1'b0;
          else if (force_trig) force_d = 1'b1;
          if (trig_hit) begin
            trig_ptr_d = wr_ptr_q;
            post_d     = ~pre_q;
            state_d    = (pre_q == {DEPTH_LOG2{1'b1}}) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (tick) begin
            post_d = post_q - ptr_t'(1);
            if (post_q == ptr_t'(1)) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      div_q      <= '0;
      pre_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      trig_ptr_q <= '0;
      force_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      pre_q      <= pre_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      trig_ptr_q <= trig_ptr_d;
      force_q    <= force_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tick) mem[wr_ptr_q] <= digital_in;
  end

  // Oldest sample sits pre_len entries before the trigger; same-cycle write returns old data.
  assign rd_phys = trig_ptr_q - pre_q + rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem[rd_phys];
    end
  end

  assign busy     = capturing;
  assign armed    = (state_q == S_WAIT);
  assign done     = (state_q == S_DONE);
  assign trig_ptr = trig_ptr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_analyzer_capture_core.sv
// tb/tb_analyzer_capture_core.sv - directed self-checking bench for analyzer_capture_core
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_analyzer_capture_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  digital_in;
  logic        start, stop, trig, force_trig;
  logic [15:0] clk_div;
  logic [3:0]  pre_len;
  logic        busy, armed, done;
  logic [3:0]  trig_ptr;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  analyzer_capture_core #(.CH_NUM(8), .DEPTH_LOG2(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .digital_in(digital_in), .start(start), .stop(stop),
    .trig(trig), .force_trig(force_trig), .clk_div(clk_div), .pre_len(pre_len),
    .busy(busy), .armed(armed), .done(done), .trig_ptr(trig_ptr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    digital_in = digital_in + 8'd1;
  endtask

  task automatic go(input int div, input int pre);
    clk_div = div[15:0];
    pre_len = pre[3:0];
    start = 1'b1;
    cyc();
    start = 1'b0;
    digital_in = 8'd0;
  endtask

  task automatic rd(input string tag, input int a, input int e);
    rd_en = 1'b1;
    rd_addr = a[3:0];
    cyc();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, e[7:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; digital_in = 8'd0; start = 1'b0; stop = 1'b0; trig = 1'b0;
    force_trig = 1'b0; clk_div = 16'd0; pre_len = 4'd0; rd_en = 1'b0; rd_addr = 4'd0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_ptr", trig_ptr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // basic capture: pre_len 4, trigger on sample 10
    go(0, 4);
    chk("c1_busy_pre", busy, 1);
    chk("c1_armed_pre", armed, 0);
    repeat (3) cyc();
    chk("c1_armed_c3", armed, 0);
    cyc();
    chk("c1_armed_c4", armed, 1);
    repeat (6) cyc();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    chk("c1_armed_post", armed, 0);
    chk("c1_busy_post", busy, 1);
    chk("c1_trig_ptr", trig_ptr, 10);
    repeat (10) cyc();
    chk("c1_done_early", done, 0);
    chk("c1_busy_last", busy, 1);
    cyc();
    chk("c1_done", done, 1);
    chk("c1_busy_done", busy, 0);
    rd("c1_rd0", 0, 6);
    rd("c1_rd4", 4, 10);
    rd("c1_rd15", 15, 21);
    cyc();
    chk("c1_rd_valid_drop", rd_valid, 0);
    repeat (3) cyc();
    chk("c1_done_hold", done, 1);
    chk("c1_trig_ptr_hold", trig_ptr, 10);

    // divided rate, immediate trigger
    trig = 1'b1;
    go(3, 0);
    chk("c2_armed_c0", armed, 1);
    repeat (3) cyc();
    chk("c2_armed_c3", armed, 1);
    cyc();
    chk("c2_armed_c4", armed, 0);
    chk("c2_trig_ptr", trig_ptr, 0);
    n = 4;
    while (busy && n < 200) begin
      n++;
      cyc();
    end
    chk("c2_busy_cycles", n, 64);
    chk("c2_done", done, 1);
    rd("c2_rd0", 0, 3);
    rd("c2_rd15", 15, 63);

    // trigger held during PRE is ignored
    go(0, 6);
    repeat (5) cyc();
    chk("c3_busy_c5", busy, 1);
    chk("c3_armed_c5", armed, 0);
    cyc();
    chk("c3_armed_c6", armed, 1);
    cyc();
    chk("c3_armed_c7", armed, 0);
    chk("c3_trig_ptr", trig_ptr, 6);
    repeat (9) cyc();
    chk("c3_done", done, 1);
    rd("c3_rd0", 0, 0);
    rd("c3_rd6", 6, 6);

    // maximum pre_len: trigger goes straight to DONE
    go(0, 15);
    repeat (15) cyc();
    chk("c4_armed_c15", armed, 1);
    cyc();
    chk("c4_done", done, 1);
    chk("c4_trig_ptr", trig_ptr, 15);
    rd("c4_rd15", 15, 15);
    rd("c4_rd0", 0, 0);

    // forced trigger, then stop mid-POST
    trig = 1'b0;
    go(1, 2);
    n = 0;
    while (!armed && n < 20) begin
      n++;
      cyc();
    end
    chk("c5_armed", armed, 1);
    force_trig = 1'b1;
    cyc();
    force_trig = 1'b0;
    chk("c5_armed_latched", armed, 1);
    cyc();
    chk("c5_armed_fired", armed, 0);
    chk("c5_busy_post", busy, 1);
    chk("c5_trig_ptr", trig_ptr, 2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("c5_stop_busy", busy, 0);
    chk("c5_stop_done", done, 0);
    chk("c5_stop_armed", armed, 0);

    // start and stop together stay in IDLE
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("c6_busy", busy, 0);
    cyc();
    chk("c6_busy_later", busy, 0);

    // async reset while waiting for trigger
    go(0, 2);
    repeat (2) cyc();
    chk("c7_armed", armed, 1);
    rd_en = 1'b1;
    cyc();
    chk("c7_rd_valid_pre", rd_valid, 1);
    chk("c7_trig_ptr_pre", trig_ptr, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("c7_busy", busy, 0);
    chk("c7_armed_rst", armed, 0);
    chk("c7_done", done, 0);
    chk("c7_rd_valid", rd_valid, 0);
    chk("c7_trig_ptr", trig_ptr, 0);
    chk("c7_rd_data", rd_data, 0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("c7_idle", busy, 0);
    trig = 1'b1;
    go(0, 0);
    n = 0;
    while (!done && n < 40) begin
      n++;
      cyc();
    end
    trig = 1'b0;
    chk("c7_restart_cycles", n, 16);
    chk("c7_restart_trig_ptr", trig_ptr, 0);
    rd("c7_rd0", 0, 0);
    rd("c7_rd15", 15, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
